// File: rtl/audio_i2s_fifo_tx.sv
// Stereo I2S transmitter: buffers L/R pairs, attenuates by volume shift, emits SCK/BCK/LRCK/DATA.
// Outputs register one clk after the free-running frame counter; input pairs are dropped when the FIFO is full.
module audio_i2s_fifo_tx #(
    parameter int IN_WIDTH = 16,
    parameter int FIFO_AW  = 3,
    parameter int SCK_DIV  = 6,
    parameter int BCK_DIV  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] in_left,
    input  logic [IN_WIDTH-1:0] in_right,
    input  logic                in_valid,
    input  logic [3:0]          volume,
    output logic                SCK,
    output logic                BCK,
    output logic                LRCK,
    output logic                DATA,
    output logic [FIFO_AW:0]    fifo_level,
    output logic                underflow,
    output logic                overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int SW    = $clog2(SCK_DIV);
    localparam int BW    = $clog2(BCK_DIV);

    localparam logic [SW-1:0]    SCK_LAST = SW'(SCK_DIV - 1);
    localparam logic [SW-1:0]    SCK_HALF = SW'(SCK_DIV / 2);
    localparam logic [BW-1:0]    BCK_LAST = BW'(BCK_DIV - 1);
    localparam logic [BW-1:0]    BCK_HALF = BW'(BCK_DIV / 2);
    localparam logic [4:0]       LAST_BIT = 5'(IN_WIDTH);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

    // fc is kept as three aligned sub-counters: fc = slot*BCK_DIV + bck_cnt
    logic [SW-1:0] sck_cnt;
    logic [BW-1:0] bck_cnt;
    logic [5:0]    slot;

    logic [2*IN_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic [FIFO_AW:0]      count;

    logic [IN_WIDTH-1:0] left_sr, right_sr;

    logic fc_zero, empty, full, pop, push, bit_slot;
    logic signed [IN_WIDTH-1:0] head_l, head_r, att_l, att_r;

    assign fc_zero  = (slot == 6'd0) && (bck_cnt == '0);
    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign pop      = fc_zero && !empty;
    assign push     = in_valid && (!full || pop);
    assign bit_slot = (slot[4:0] != 5'd0) && (slot[4:0] <= LAST_BIT);

    assign head_l = mem[rd_ptr][2*IN_WIDTH-1:IN_WIDTH];
    assign head_r = mem[rd_ptr][IN_WIDTH-1:0];
    assign att_l  = head_l >>> volume;
    assign att_r  = head_r >>> volume;

    assign fifo_level = count;

    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr] <= {in_left, in_right};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_cnt   <= '0;
            bck_cnt   <= '0;
            slot      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            left_sr   <= '0;
            right_sr  <= '0;
            SCK       <= 1'b0;
            BCK       <= 1'b0;
            LRCK      <= 1'b0;
            DATA      <= 1'b0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sck_cnt <= (sck_cnt == SCK_LAST) ? '0 : sck_cnt + 1'b1;
            bck_cnt <= (bck_cnt == BCK_LAST) ? '0 : bck_cnt + 1'b1;
            if (bck_cnt == BCK_LAST)
                slot <= slot + 6'd1;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            if (in_valid && full && !pop)
                overflow <= 1'b1;

            SCK  <= (sck_cnt >= SCK_HALF);
            BCK  <= (bck_cnt >= BCK_HALF);
            LRCK <= slot[5];

            // Slot 0 of each channel is the I2S one-BCK delay, so loading here never races a shift
            if (fc_zero) begin
                left_sr  <= pop ? att_l : '0;
                right_sr <= pop ? att_r : '0;
                if (empty)
                    underflow <= 1'b1;
            end

            if (bck_cnt == '0) begin
                if (!bit_slot)
                    DATA <= 1'b0;
                else if (!slot[5])
                    {DATA, left_sr} <= {left_sr, 1'b0};
                else
                    {DATA, right_sr} <= {right_sr, 1'b0};
            end
        end
    end
endmodule
